// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: one-hot column strobe, debounced press/release, valid/ready key output.
// Optional macro KEYPAD_ROW_SYNC_EN adds a 2-flop synchroniser on row_in.
module keypad_matrix_scanner #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 4,
    parameter int DEBOUNCE_TICKS = 8,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_tick,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [CW-1:0]       col_index,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [CW+RW-1:0]    key_code
);

    localparam int CNTW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNTW-1:0] CMAX = CNTW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_ROWS-1:0] row_s;
    logic [NUM_ROWS-1:0] pat, pat_nxt;
    logic [CNTW-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [NUM_COLS-1:0] col_out_nxt;
    logic [CW-1:0]       col_index_nxt;
    logic                key_valid_nxt;
    logic [CW+RW-1:0]    key_code_nxt;
    logic                advance;
    logic                accept;

    // Lowest set row wins when several rows are closed together.
    function automatic logic [RW-1:0] low_row(input logic [NUM_ROWS-1:0] r);
        low_row = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (r[i]) low_row = RW'(i);
        end
    endfunction

`ifdef KEYPAD_ROW_SYNC_EN
    logic [NUM_ROWS-1:0] sync1, sync2;

    // Two-flop synchroniser for asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= row_in;
            sync2 <= sync1;
        end
    end

    assign row_s = sync2;
`else
    assign row_s = row_in;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            pat       <= '0;
            cnt       <= '0;
            col_out   <= NUM_COLS'(1);
            col_index <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_nxt;
            pat       <= pat_nxt;
            cnt       <= cnt_nxt;
            col_out   <= col_out_nxt;
            col_index <= col_index_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
        end
    end

    // Next-state, debounce counting, column advance and key capture.
    always_comb begin
        state_nxt     = state;
        pat_nxt       = pat;
        cnt_nxt       = cnt;
        col_out_nxt   = col_out;
        col_index_nxt = col_index;
        key_valid_nxt = key_valid;
        key_code_nxt  = key_code;
        advance       = 1'b0;
        accept        = 1'b0;
        cnt_inc       = (cnt == CMAX) ? cnt : cnt + CNTW'(1);

        unique case (state)
            SCAN: begin
                if (scan_tick) begin
                    if (row_s == '0) begin
                        advance = 1'b1;
                    end else begin
                        pat_nxt = row_s;
                        cnt_nxt = CNTW'(1);
                        if (DEBOUNCE_TICKS == 1) accept = 1'b1;
                        else state_nxt = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (scan_tick) begin
                    if (row_s == pat) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CMAX) accept = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                        advance   = 1'b1;
                    end
                end
            end
            REPORT: begin
                if (key_valid && key_ready) begin
                    key_valid_nxt = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = RELEASE;
                end
            end
            RELEASE: begin
                if (scan_tick) begin
                    if (row_s == '0) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CMAX) begin
                            state_nxt = SCAN;
                            advance   = 1'b1;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase

        if (accept) begin
            state_nxt     = REPORT;
            key_valid_nxt = 1'b1;
            key_code_nxt  = {col_index, low_row(row_s)};
        end

        if (advance) begin
            col_out_nxt   = {col_out[NUM_COLS-2:0], col_out[NUM_COLS-1]};
            col_index_nxt = (col_index == CW'(NUM_COLS - 1)) ? '0 : col_index + CW'(1);
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: directed table, corner sequences,
// random stimulus against a tick-level reference model, plus a 3-column build.
module tb_keypad_matrix_scanner;

    localparam int NC = 4;
    localparam int D  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_tick;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [1:0] col_index;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;

    logic [3:0] row3 = 4'b0;
    logic       ready3 = 1'b0;
    logic [2:0] col_out3;
    logic [1:0] col_index3;
    logic       key_valid3;
    logic [3:0] key_code3;

    int ntests = 0;
    int nfail  = 0;

    keypad_matrix_scanner #(
        .NUM_COLS(NC), .NUM_ROWS(4), .DEBOUNCE_TICKS(D)
    ) dut (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .row_in(row_in),
        .col_out(col_out), .col_index(col_index), .key_valid(key_valid),
        .key_ready(key_ready), .key_code(key_code)
    );

    keypad_matrix_scanner #(
        .NUM_COLS(3), .NUM_ROWS(4), .DEBOUNCE_TICKS(D)
    ) dut3 (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .row_in(row3),
        .col_out(col_out3), .col_index(col_index3), .key_valid(key_valid3),
        .key_ready(ready3), .key_code(key_code3)
    );

    always #5 clk = ~clk;

    // Reference model, advanced once per clk edge.
    // mode: 0 scanning, 1 confirming press, 2 holding key for consumer, 3 confirming release
    int       m_col, m_mode, m_run, c3;
    bit [3:0] m_pat;
    bit       m_valid;
    bit [3:0] m_code;

    function automatic int lowbit(bit [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_col = 0; m_mode = 0; m_run = 0; m_pat = 0;
        m_valid = 0; m_code = 0; c3 = 0;
    endtask

    task automatic model_edge(bit t, bit [3:0] r, bit k);
        if (t) c3 = (c3 + 1) % 3;
        if (m_mode == 2) begin
            if (k) begin
                m_valid = 0; m_mode = 3; m_run = 0;
            end
            return;
        end
        if (!t) return;
        if (m_mode == 0) begin
            if (r == 0) m_col = (m_col + 1) % NC;
            else begin
                m_pat = r; m_run = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (r == m_pat) m_run++;
            else begin
                m_mode = 0; m_col = (m_col + 1) % NC;
            end
        end else begin
            if (r == 0) m_run++;
            else m_run = 0;
            if (m_run >= D) begin
                m_mode = 0; m_col = (m_col + 1) % NC;
            end
        end
        if (m_mode == 1 && m_run >= D) begin
            m_mode = 2; m_valid = 1;
            m_code = 4'(m_col * 4 + lowbit(r));
        end
    endtask

    task automatic chk(string name, int got, int want);
        ntests++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // One clk of stimulus; with the synchroniser built in, rows are presented 2 clk early.
    task automatic step(bit t, bit [3:0] r, bit k);
        row_in = r;
`ifdef KEYPAD_ROW_SYNC_EN
        scan_tick = 1'b0;
        key_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_edge(1'b0, r, 1'b0);
            #1;
        end
`endif
        scan_tick = t;
        key_ready = k;
        @(posedge clk);
        model_edge(t, r, k);
        #1;
        scan_tick = 1'b0;
        chk("col3_index", int'(col_index3), c3);
        chk("col3_onehot", int'(col_out3), 1 << c3);
    endtask

    task automatic chk_model();
        chk("m_col_index", int'(col_index), m_col);
        chk("m_col_out", int'(col_out), 1 << m_col);
        chk("m_valid", int'(key_valid), int'(m_valid));
        if (m_valid) chk("m_code", int'(key_code), int'(m_code));
    endtask

    typedef struct {
        bit       t;
        bit [3:0] r;
        bit       k;
        int       col;
        bit       v;
        bit [3:0] code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit t, bit [3:0] r, bit k, int col, bit v, bit [3:0] code);
        vec_t x;
        x.t = t; x.r = r; x.k = k; x.col = col; x.v = v; x.code = code;
        return x;
    endfunction

    initial begin
        rst = 1'b1; scan_tick = 1'b0; row_in = 4'b0; key_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col_index", int'(col_index), 0);
        chk("rst_col_out", int'(col_out), 1);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code", int'(key_code), 0);
        @(negedge clk);
        rst = 1'b0;

        // scan rotation
        for (int i = 1; i <= 6; i++) tbl.push_back(mk(1, 4'h0, 1, i % 4, 0, 0));
        // press at column 2, accepted and consumed immediately
        tbl.push_back(mk(1, 4'h4, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 1, 2, 1, 4'hA));
        tbl.push_back(mk(0, 4'h4, 1, 2, 0, 0));
        // release confirmation then advance
        tbl.push_back(mk(1, 4'h0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 3, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 1, 0, 0));
        // bounce at column 1
        tbl.push_back(mk(1, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 3, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0));
        // multi-row press at column 0, consumer not ready
        tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 0, 1, 4'h1));

        foreach (tbl[i]) begin
            step(tbl[i].t, tbl[i].r, tbl[i].k);
            chk($sformatf("tbl%0d_col_index", i), int'(col_index), tbl[i].col);
            chk($sformatf("tbl%0d_col_out", i), int'(col_out), 1 << tbl[i].col);
            chk($sformatf("tbl%0d_valid", i), int'(key_valid), int'(tbl[i].v));
            if (tbl[i].v)
                chk($sformatf("tbl%0d_code", i), int'(key_code), int'(tbl[i].code));
        end

        // backpressure: rows and ticks churn, output must hold
        for (int i = 0; i < 20; i++) begin
            step(i[0], i[0] ? 4'hF : 4'h0, 0);
            chk("bp_valid", int'(key_valid), 1);
            chk("bp_code", int'(key_code), 1);
            chk("bp_col", int'(col_index), 0);
        end
        step(0, 4'hA, 1);
        chk("bp_ack_valid", int'(key_valid), 0);
        // key held: no repeat, column frozen
        for (int i = 0; i < 50; i++) begin
            step(1, 4'hA, 1);
            chk("hold_valid", int'(key_valid), 0);
            chk("hold_col", int'(col_index), 0);
        end
        step(1, 4'h0, 1);
        step(1, 4'h0, 1);
        chk("rel2_col", int'(col_index), 0);
        step(1, 4'h0, 1);
        chk("rel3_col", int'(col_index), 1);

        // asynchronous reset while a key is pending
        for (int i = 0; i < 3; i++) step(1, 4'h2, 0);
        chk("pre_rst_valid", int'(key_valid), 1);
        chk("pre_rst_code", int'(key_code), 4'h5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(key_valid), 0);
        chk("mid_rst_col_out", int'(col_out), 1);
        chk("mid_rst_col_index", int'(col_index), 0);
        chk("mid_rst_col3", int'(col_index3), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // randomized stimulus against the reference model
        begin
            bit [3:0] r;
            r = 4'h0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 5) == 0)
                    r = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                step($urandom_range(0, 2) == 0, r, $urandom_range(0, 3) == 0);
                chk_model();
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
